// File: rtl/count8_down_timer.sv
// ---------------------------------------------------------------------------
// count8_down_timer
//
// Loadable down-counter/timer. A loaded value is counted down to zero through
// a programmable prescaler. Reaching zero ("expiry") produces a one-cycle done
// pulse. The timer then either reloads the last loaded value and keeps
// running, or parks in EXPIRED until the next load or reset.
//
// Optional build macro:
//   COUNT8_DOWN_EXPCNT_EN - when defined, exp_cnt is a saturating count of
//                           expiries. When undefined, exp_cnt is tied to 0.
//                           The port list is the same in both builds.
//
// Ports:
//   clk          in   single clock, rising edge
//   res          in   synchronous active-high reset, highest priority
//   EN           in   count enable; 0 freezes the counter and the prescaler
//   load         in   load CNT_In into CNT and the reload register
//   CNT_In       in   [WIDTH-1:0] load value
//   presc        in   [PW-1:0] prescaler compare, tick every presc+1 cycles
//   auto_reload  in   1 = reload on expiry and keep running
//   CNT          out  [WIDTH-1:0] current count (registered)
//   busy         out  high while counting (RUN)
//   expired      out  high while parked at zero (EXPIRED)
//   done         out  one-cycle registered pulse on each expiry
//   exp_cnt      out  [7:0] expiry counter (0 unless the macro is defined)
// ---------------------------------------------------------------------------
module count8_down_timer #(
    parameter int WIDTH = 8,
    parameter int PW    = 4
) (
    input  logic             clk,
    input  logic             res,
    input  logic             EN,
    input  logic             load,
    input  logic [WIDTH-1:0] CNT_In,
    input  logic [PW-1:0]    presc,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] CNT,
    output logic             busy,
    output logic             expired,
    output logic             done,
    output logic [7:0]       exp_cnt
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_EXPIRED = 2'd2;

    logic [1:0]       state_q,     state_d;
    logic [WIDTH-1:0] cnt_q,       cnt_d;
    logic [WIDTH-1:0] reload_q,    reload_d;
    logic [PW-1:0]    presc_cnt_q, presc_cnt_d;
    logic             done_q,      done_d;

    // Next-state logic. load beats any tick in the same cycle, so a load that
    // lands on an expiry edge never produces a done pulse. The prescaler uses
    // >= so that lowering presc mid-run ticks immediately instead of waiting
    // for the internal counter to wrap.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        reload_d    = reload_q;
        presc_cnt_d = presc_cnt_q;
        done_d      = 1'b0;

        if (load) begin
            cnt_d       = CNT_In;
            reload_d    = CNT_In;
            presc_cnt_d = '0;
            state_d     = (CNT_In != '0) ? ST_RUN : ST_IDLE;
        end else if ((state_q == ST_RUN) && EN) begin
            if (presc_cnt_q >= presc) begin
                presc_cnt_d = '0;
                if (cnt_q > WIDTH'(1)) begin
                    cnt_d = cnt_q - WIDTH'(1);
                end else if (cnt_q == WIDTH'(1)) begin
                    done_d = 1'b1;
                    if (auto_reload) begin
                        cnt_d = reload_q;
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_EXPIRED;
                    end
                end else begin
                    // A zero count in RUN cannot be reached through load;
                    // park safely rather than wrap around.
                    state_d = ST_EXPIRED;
                end
            end else begin
                presc_cnt_d = presc_cnt_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            reload_q    <= '0;
            presc_cnt_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            reload_q    <= reload_d;
            presc_cnt_q <= presc_cnt_d;
            done_q      <= done_d;
        end
    end

`ifdef COUNT8_DOWN_EXPCNT_EN
    logic [7:0] exp_cnt_q, exp_cnt_d;

    // Expiry counter advances on the same edge that raises done and sticks
    // at all-ones. Only res clears it; load leaves it alone.
    always_comb begin
        exp_cnt_d = exp_cnt_q;
        if (done_d && (exp_cnt_q != 8'hFF)) begin
            exp_cnt_d = exp_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            exp_cnt_q <= 8'h00;
        end else begin
            exp_cnt_q <= exp_cnt_d;
        end
    end

    assign exp_cnt = exp_cnt_q;
`else
    assign exp_cnt = 8'h00;
`endif

    assign CNT     = cnt_q;
    assign busy    = (state_q == ST_RUN);
    assign expired = (state_q == ST_EXPIRED);
    assign done    = done_q;

endmodule

// File: tb/tb_count8_down_timer.sv
// ---------------------------------------------------------------------------
// tb_count8_down_timer
//
// Directed bench for count8_down_timer. Each step drives the inputs, queues
// the outputs expected after the next rising edge, and then checks the DUT
// against the front of the queue. The expected expiry count follows the
// COUNT8_DOWN_EXPCNT_EN macro, so the same bench covers both builds.
// ---------------------------------------------------------------------------
module tb_count8_down_timer;

    logic       clk = 1'b0;
    logic       res;
    logic       EN;
    logic       load;
    logic [7:0] CNT_In;
    logic [3:0] presc;
    logic       auto_reload;
    logic [7:0] CNT;
    logic       busy;
    logic       expired;
    logic       done;
    logic [7:0] exp_cnt;

    typedef struct packed {
        logic [7:0] cnt;
        logic       busy;
        logic       expired;
        logic       done;
        logic [7:0] expc;
    } exp_t;

    exp_t  scoreboard[$];
    string tagQueue[$];
    int    testCount  = 0;
    int    failCount  = 0;
    int    expiryTally = 0;

    count8_down_timer #(.WIDTH(8), .PW(4)) dut (
        .clk         (clk),
        .res         (res),
        .EN          (EN),
        .load        (load),
        .CNT_In      (CNT_In),
        .presc       (presc),
        .auto_reload (auto_reload),
        .CNT         (CNT),
        .busy        (busy),
        .expired     (expired),
        .done        (done),
        .exp_cnt     (exp_cnt)
    );

    always #5 clk = ~clk;

    // Expected expiry counter value derived from the bench's own tally.
    function automatic logic [7:0] expectedExpCnt();
`ifdef COUNT8_DOWN_EXPCNT_EN
        return (expiryTally > 255) ? 8'hFF : 8'(expiryTally);
`else
        return 8'h00;
`endif
    endfunction

    // Pop the oldest expectation and compare every output against it.
    task automatic checkOutput();
        exp_t  e;
        string tag;
        testCount++;
        assert (scoreboard.size() != 0)
        else begin
            failCount++;
            $error("[TB] FAIL scoreboard_empty: got 0 entries, expected at least 1");
        end
        if (scoreboard.size() != 0) begin
            e   = scoreboard.pop_front();
            tag = tagQueue.pop_front();
            testCount++;
            assert (CNT === e.cnt)
            else begin
                failCount++;
                $error("[TB] FAIL %s CNT: got %h expected %h", tag, CNT, e.cnt);
            end
            testCount++;
            assert (busy === e.busy)
            else begin
                failCount++;
                $error("[TB] FAIL %s busy: got %b expected %b", tag, busy, e.busy);
            end
            testCount++;
            assert (expired === e.expired)
            else begin
                failCount++;
                $error("[TB] FAIL %s expired: got %b expected %b", tag, expired, e.expired);
            end
            testCount++;
            assert (done === e.done)
            else begin
                failCount++;
                $error("[TB] FAIL %s done: got %b expected %b", tag, done, e.done);
            end
            testCount++;
            assert (exp_cnt === e.expc)
            else begin
                failCount++;
                $error("[TB] FAIL %s exp_cnt: got %h expected %h", tag, exp_cnt, e.expc);
            end
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge outputs, clock
    // once and check.
    task automatic applyStimulus(
        input logic       r,
        input logic       l,
        input logic       e,
        input logic [7:0] cin,
        input logic [3:0] p,
        input logic       ar,
        input logic [7:0] eCnt,
        input logic       eBusy,
        input logic       eExpired,
        input logic       eDone,
        input string      tag
    );
        exp_t x;
        res         = r;
        load        = l;
        EN          = e;
        CNT_In      = cin;
        presc       = p;
        auto_reload = ar;
        if (r) expiryTally = 0;
        else if (eDone) expiryTally++;
        x.cnt     = eCnt;
        x.busy    = eBusy;
        x.expired = eExpired;
        x.done    = eDone;
        x.expc    = expectedExpCnt();
        scoreboard.push_back(x);
        tagQueue.push_back(tag);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        res = 1'b1; load = 1'b0; EN = 1'b0; CNT_In = 8'h00; presc = 4'd0; auto_reload = 1'b0;

        // Reset wins over a coincident load.
        applyStimulus(1, 1, 1, 8'h55, 0, 0, 8'h00, 0, 0, 0, "reset0");
        applyStimulus(1, 1, 1, 8'h55, 0, 0, 8'h00, 0, 0, 0, "reset1");
        applyStimulus(0, 0, 1, 8'h55, 0, 0, 8'h00, 0, 0, 0, "idle_hold");

        // Basic count 3 -> 0 with presc=0.
        applyStimulus(0, 1, 1, 8'h03, 0, 0, 8'h03, 1, 0, 0, "basic_load");
        applyStimulus(0, 0, 1, 8'h00, 0, 0, 8'h02, 1, 0, 0, "basic_2");
        applyStimulus(0, 0, 1, 8'h00, 0, 0, 8'h01, 1, 0, 0, "basic_1");
        applyStimulus(0, 0, 1, 8'h00, 0, 0, 8'h00, 0, 1, 1, "basic_expire");
        for (int i = 0; i < 5; i++)
            applyStimulus(0, 0, 1, 8'h00, 0, 0, 8'h00, 0, 1, 0, "basic_held");

        // Prescale by 3 with a 4-cycle pause in the middle.
        applyStimulus(0, 1, 1, 8'h02, 2, 0, 8'h02, 1, 0, 0, "presc_load");
        applyStimulus(0, 0, 1, 8'h00, 2, 0, 8'h02, 1, 0, 0, "presc_p1");
        applyStimulus(0, 0, 1, 8'h00, 2, 0, 8'h02, 1, 0, 0, "presc_p2");
        applyStimulus(0, 0, 1, 8'h00, 2, 0, 8'h01, 1, 0, 0, "presc_tick");
        applyStimulus(0, 0, 1, 8'h00, 2, 0, 8'h01, 1, 0, 0, "presc_p1b");
        for (int i = 0; i < 4; i++)
            applyStimulus(0, 0, 0, 8'h00, 2, 0, 8'h01, 1, 0, 0, "presc_pause");
        applyStimulus(0, 0, 1, 8'h00, 2, 0, 8'h01, 1, 0, 0, "presc_resume");
        applyStimulus(0, 0, 1, 8'h00, 2, 0, 8'h00, 0, 1, 1, "presc_expire");
        applyStimulus(0, 0, 1, 8'h00, 2, 0, 8'h00, 0, 1, 0, "presc_after");

        // Lowering presc mid-run ticks at once.
        applyStimulus(0, 1, 1, 8'h03, 5, 0, 8'h03, 1, 0, 0, "lower_load");
        applyStimulus(0, 0, 1, 8'h00, 5, 0, 8'h03, 1, 0, 0, "lower_p1");
        applyStimulus(0, 0, 1, 8'h00, 5, 0, 8'h03, 1, 0, 0, "lower_p2");
        applyStimulus(0, 0, 1, 8'h00, 1, 0, 8'h02, 1, 0, 0, "lower_tick");
        applyStimulus(0, 0, 1, 8'h00, 1, 0, 8'h02, 1, 0, 0, "lower_p1c");
        applyStimulus(0, 0, 1, 8'h00, 1, 0, 8'h01, 1, 0, 0, "lower_tick2");

        // Auto-reload from a clean reset: 2,1,2,1,... with done on each wrap.
        applyStimulus(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, "ar_reset");
        applyStimulus(0, 1, 1, 8'h02, 0, 1, 8'h02, 1, 0, 0, "ar_load");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 1, 8'h00, 0, 1, 8'h01, 1, 0, 0, "ar_one");
            applyStimulus(0, 0, 1, 8'h00, 0, 1, 8'h02, 1, 0, 1, "ar_wrap");
        end
        applyStimulus(0, 0, 1, 8'h00, 0, 1, 8'h01, 1, 0, 0, "ar_one_again");

        // Priorities: load on an expiry edge, reset with load, load of zero.
        applyStimulus(0, 1, 1, 8'h11, 0, 1, 8'h11, 1, 0, 0, "prio_load_on_expiry");
        applyStimulus(1, 1, 1, 8'h22, 0, 0, 8'h00, 0, 0, 0, "prio_reset_load");
        applyStimulus(0, 1, 1, 8'h00, 0, 0, 8'h00, 0, 0, 0, "prio_load_zero");
        applyStimulus(0, 0, 1, 8'h00, 0, 0, 8'h00, 0, 0, 0, "prio_zero_idle");

        // Saturation: reload value 1 expires on every enabled edge.
        applyStimulus(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, "sat_reset");
        applyStimulus(0, 1, 1, 8'h01, 0, 1, 8'h01, 1, 0, 0, "sat_load");
        for (int i = 0; i < 300; i++)
            applyStimulus(0, 0, 1, 8'h00, 0, 1, 8'h01, 1, 0, 1, "sat_run");

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
